// File: rtl/dpram_rptr_empty_pkg.sv
// rtl/dpram_rptr_empty_pkg.sv - default geometry and Gray helper for dpram_rptr_empty
package dpram_rptr_empty_pkg;

  localparam int DEFAULT_DATA_SIZE = 8;
  localparam int DEFAULT_ADD_SIZE  = 3;

  // Binary to reflected Gray; callers truncate to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// rtl/sync_r2w.sv - two-flop pointer synchronizer chain
module sync_r2w #(
  parameter int WIDTH = 4
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [WIDTH-1:0] ptr_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two register stages; both clear on reset so the far side starts at pointer 0.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= ptr_i;
      sync_q <= meta_q;
    end
  end

  assign ptr_o = sync_q;

endmodule

// File: rtl/dpram_rptr_empty.sv
// rtl/dpram_rptr_empty.sv - single-clock FIFO with Gray pointers and synchronized flags (optional DPRAM_RPTR_EMPTY_WARN_EN)
module dpram_rptr_empty
  import dpram_rptr_empty_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int ADD_SIZE  = DEFAULT_ADD_SIZE
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] di,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic [ADD_SIZE:0]    rd_ptr,
  output logic [ADD_SIZE:0]    rd_ptr_sync
);

  // Pointer width includes one wrap bit above the address; ADD_SIZE must be >= 2.
  localparam int PW    = ADD_SIZE + 1;
  localparam int DEPTH = 1 << ADD_SIZE;

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic [PW-1:0]        wbin_q, wbin_d, rbin_q, rbin_d;
  logic [PW-1:0]        wgray_q, wgray_d, rgray_q, rgray_d;
  logic [PW-1:0]        wr_ptr_s, rd_ptr_s;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 full_q, full_d, empty_q, empty_d;
  logic                 wr_acc, rd_acc;

  // Acceptance, next pointers and next flags; flags compare against the delayed far-side pointer.
  always_comb begin
    wr_acc  = wr_en && !full_q;
    rd_acc  = rd_en && !empty_q;
    wbin_d  = wbin_q + PW'(wr_acc);
    rbin_d  = rbin_q + PW'(rd_acc);
    wgray_d = PW'(bin2gray(32'(wbin_d)));
    rgray_d = PW'(bin2gray(32'(rbin_d)));
    dout_d  = rd_acc ? mem[rbin_q[ADD_SIZE-1:0]] : dout_q;
    empty_d = (rgray_d == wr_ptr_s);
    full_d  = (wgray_d == {~rd_ptr_s[PW-1:PW-2], rd_ptr_s[PW-3:0]});
  end

  // Pointer, data and flag registers.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst) begin
      wbin_q  <= '0;
      rbin_q  <= '0;
      wgray_q <= '0;
      rgray_q <= '0;
      dout_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wbin_q  <= wbin_d;
      rbin_q  <= rbin_d;
      wgray_q <= wgray_d;
      rgray_q <= rgray_d;
      dout_q  <= dout_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage array; contents survive reset, writes are blocked during the reset cycle.
  always_ff @(posedge rd_clk) begin
    if (rd_rst && wr_acc) begin
      mem[wbin_q[ADD_SIZE-1:0]] <= di;
    end
  end

  sync_r2w #(.WIDTH(PW)) u_sync_wptr (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .ptr_i  (wgray_q),
    .ptr_o  (wr_ptr_s)
  );

  sync_r2w #(.WIDTH(PW)) u_sync_rptr (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .ptr_i  (rgray_q),
    .ptr_o  (rd_ptr_s)
  );

  assign dout        = dout_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign rd_ptr      = rgray_q;
  assign rd_ptr_sync = rd_ptr_s;

`ifdef DPRAM_RPTR_EMPTY_WARN_EN
  // Simulation-only notice when a request is dropped because of a flag.
  always @(posedge rd_clk) begin
    if (wr_en && full_q) $display("%m: warning: write while full ignored at %0t", $time);
    if (rd_en && empty_q) $display("%m: warning: read while empty ignored at %0t", $time);
  end
`endif

endmodule

// File: tb/tb_dpram_rptr_empty.sv
// tb/tb_dpram_rptr_empty.sv - self-checking bench for dpram_rptr_empty
module tb_dpram_rptr_empty;

  logic       rd_clk = 1'b0;
  logic       rd_rst = 1'b0;
  logic       wr_en  = 1'b0;
  logic [7:0] di     = 8'h00;
  logic       rd_en  = 1'b0;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic [3:0] rd_ptr;
  logic [3:0] rd_ptr_sync;

  dpram_rptr_empty #(.DATA_SIZE(8), .ADD_SIZE(3)) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .wr_en       (wr_en),
    .di          (di),
    .rd_en       (rd_en),
    .dout        (dout),
    .full        (full),
    .empty       (empty),
    .rd_ptr      (rd_ptr),
    .rd_ptr_sync (rd_ptr_sync)
  );

  always #5 rd_clk = ~rd_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: stored words in a queue, accepted-operation counts with
  // a short history so flags see the far-side count three edges late.
  logic [7:0] q[$];
  int         w_h[4];
  int         r_h[4];
  logic [7:0] m_dout;
  bit         m_full;
  bit         m_empty;
  logic [3:0] prev_rd_ptr;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rstn, input bit wr, input logic [7:0] d, input bit rd);
    bit wa, ra;
    if (!rstn) begin
      q.delete();
      for (int i = 0; i < 4; i++) begin
        w_h[i] = 0;
        r_h[i] = 0;
      end
      m_dout  = 8'h00;
      m_empty = 1'b1;
      m_full  = 1'b0;
    end else begin
      wa = wr && !m_full;
      ra = rd && !m_empty;
      if (ra && q.size() > 0) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      for (int i = 3; i > 0; i--) begin
        w_h[i] = w_h[i-1];
        r_h[i] = r_h[i-1];
      end
      w_h[0] = w_h[0] + int'(wa);
      r_h[0] = r_h[0] + int'(ra);
      m_empty = ((w_h[3] - r_h[0]) & 15) == 0;
      m_full  = ((w_h[0] - r_h[3]) & 15) == 8;
    end
  endtask

  task automatic step(input bit rstn, input bit wr, input logic [7:0] d, input bit rd);
    int diff;
    @(negedge rd_clk);
    rd_rst = rstn;
    wr_en  = wr;
    di     = d;
    rd_en  = rd;
    @(posedge rd_clk);
    model_edge(rstn, wr, d, rd);
    #1;
    chk("dout", int'(dout), int'(m_dout));
    chk("full", int'(full), int'(m_full));
    chk("empty", int'(empty), int'(m_empty));
    chk("rd_ptr", int'(rd_ptr), int'(gray(r_h[0])));
    chk("rd_ptr_sync", int'(rd_ptr_sync), int'(gray(r_h[2])));
    if (rstn) begin
      diff = $countones(rd_ptr ^ prev_rd_ptr);
      chk("rd_ptr_gray_step_le1", int'(diff <= 1), 1);
    end
    prev_rd_ptr = rd_ptr;
  endtask

  typedef struct {
    bit         rstn;
    bit         wr;
    logic [7:0] d;
    bit         rd;
    bit         exp_full;
    bit         exp_empty;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[9];

  initial begin
    prev_rd_ptr = 4'h0;
    m_dout = 8'h00; m_full = 1'b0; m_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin w_h[i] = 0; r_h[i] = 0; end

    // Single word: reset, write at E, empty drops at E+3, read returns it.
    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5};

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rstn, vecs[i].wr, vecs[i].d, vecs[i].rd);
      chk($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].exp_full));
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_dout", i), int'(dout), int'(vecs[i].exp_dout));
      if (i == 0) begin
        chk("reset_rd_ptr", int'(rd_ptr), 0);
        chk("reset_rd_ptr_sync", int'(rd_ptr_sync), 0);
      end
    end

    // Fill to capacity, overflow write dropped, drain in order.
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
    chk("full_after_8", int'(full), 1);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    chk("full_after_9th", int'(full), 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1);
      chk($sformatf("drain%0d", i), int'(dout), i);
    end
    chk("empty_after_drain", int'(empty), 1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("read_empty_holds_dout", int'(dout), 7);

    // Twenty write/read pairs to carry the pointers through wrap.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
      for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b1);
      chk($sformatf("wrap_pair%0d", i), int'(dout), 8'h40 + i);
    end

    // Concurrent read and write at steady occupancy of four.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 8'(8'h90 + i), 1'b1);
      chk($sformatf("simul%0d_full", i), int'(full), 0);
      chk($sformatf("simul%0d_empty", i), int'(empty), 0);
      chk($sformatf("simul%0d_occ", i), q.size(), 4);
    end

    // Reset with stored entries discards them.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h55, 1'b1);
    chk("rst_empty", int'(empty), 1);
    chk("rst_dout", int'(dout), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("rst_read_ignored", int'(dout), 0);
    chk("rst_still_empty", int'(empty), 1);

    // Random traffic against the model, occasional reset.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 2) == 0 || i > 450));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
